// File: rtl/sap_ctrl_pkg.sv
// Shared encodings for the SAP control sequencer: opcodes, one-hot T-states,
// control-word bit layout and the all-inactive control word.
package sap_ctrl_pkg;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_JMP = 4'h3;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [5:0] {
        T_IDLE = 6'b000000,
        T1     = 6'b000001,
        T2     = 6'b000010,
        T3     = 6'b000100,
        T4     = 6'b001000,
        T5     = 6'b010000,
        T6     = 6'b100000
    } t_state_e;

    localparam int CW_W      = 13;
    localparam int CW_CP     = 0;
    localparam int CW_EP     = 1;
    localparam int CW_LM_BAR = 2;
    localparam int CW_CE_BAR = 3;
    localparam int CW_LI_BAR = 4;
    localparam int CW_EI_BAR = 5;
    localparam int CW_LA_BAR = 6;
    localparam int CW_EA     = 7;
    localparam int CW_SU     = 8;
    localparam int CW_EU     = 9;
    localparam int CW_LB_BAR = 10;
    localparam int CW_LO_BAR = 11;
    localparam int CW_LP_BAR = 12;

    typedef logic [CW_W-1:0] ctrl_word_t;

    // Every *_bar bit high, every active-high bit low.
    localparam ctrl_word_t CW_INACTIVE = 13'b1110001111100;

    // Drive one control to its asserted level regardless of its polarity.
    function automatic ctrl_word_t cw_assert(input ctrl_word_t cw, input int idx);
        ctrl_word_t result;
        result      = cw;
        result[idx] = ~CW_INACTIVE[idx];
        return result;
    endfunction

endpackage

// File: rtl/sap_ring_counter.sv
// Six-state one-hot T-state ring with an IDLE state that is left on the first
// advance and re-entered only through reset or clear_to_idle.
module sap_ring_counter
    import sap_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic       advance,
    input  logic       clear_to_idle,
    output logic [5:0] t_state
);

    t_state_e state_q, state_d;

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state_q <= T_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear_to_idle) begin
            state_d = T_IDLE;
        end else if (advance) begin
            case (state_q)
                T_IDLE:  state_d = T1;
                T1:      state_d = T2;
                T2:      state_d = T3;
                T3:      state_d = T4;
                T4:      state_d = T5;
                T5:      state_d = T6;
                T6:      state_d = T1;
                default: state_d = T_IDLE;
            endcase
        end
    end

    assign t_state = state_q;

endmodule

// File: rtl/sap_controller.sv
// SAP control sequencer: owns the T-state ring, the sticky halt flag and the
// opcode decode. Define SAP_CTRL_JMP_EN to decode opcode 4'h3 as JMP.
module sap_controller
    import sap_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic       run,
    input  logic [3:0] opcode,
    output logic       cp,
    output logic       ep,
    output logic       lm_bar,
    output logic       ce_bar,
    output logic       li_bar,
    output logic       ei_bar,
    output logic       la_bar,
    output logic       ea,
    output logic       su,
    output logic       eu,
    output logic       lb_bar,
    output logic       lo_bar,
    output logic       lp_bar,
    output logic [5:0] t_state,
    output logic       halted
);

    logic       halted_q, halted_d;
    logic [5:0] ring_state;
    logic       active;
    logic       halt_take;
    logic       advance;
    ctrl_word_t cw;

    assign active    = run && !halted_q && (ring_state != T_IDLE);
    // Halt is taken on the edge that ends T4, only while the sequencer runs.
    assign halt_take = active && (ring_state == T4) && (opcode == OP_HLT);
    assign advance   = run && !halted_q && !halt_take;
    assign halted_d  = halted_q | halt_take;

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_d;
        end
    end

    sap_ring_counter u_ring (
        .clk           (clk),
        .rstn          (rstn),
        .advance       (advance),
        .clear_to_idle (halt_take),
        .t_state       (ring_state)
    );

    always_comb begin
        cw = CW_INACTIVE;
        if (active) begin
            case (ring_state)
                T1: cw = cw_assert(cw_assert(cw, CW_EP), CW_LM_BAR);
                T2: cw = cw_assert(cw, CW_CP);
                T3: cw = cw_assert(cw_assert(cw, CW_CE_BAR), CW_LI_BAR);
                T4: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB:
                            cw = cw_assert(cw_assert(cw, CW_EI_BAR), CW_LM_BAR);
                        OP_OUT:
                            cw = cw_assert(cw_assert(cw, CW_EA), CW_LO_BAR);
`ifdef SAP_CTRL_JMP_EN
                        OP_JMP:
                            cw = cw_assert(cw_assert(cw, CW_EI_BAR), CW_LP_BAR);
`endif
                        default: cw = CW_INACTIVE;
                    endcase
                end
                T5: begin
                    case (opcode)
                        OP_LDA:
                            cw = cw_assert(cw_assert(cw, CW_CE_BAR), CW_LA_BAR);
                        OP_ADD, OP_SUB:
                            cw = cw_assert(cw_assert(cw, CW_CE_BAR), CW_LB_BAR);
                        default: cw = CW_INACTIVE;
                    endcase
                end
                T6: begin
                    case (opcode)
                        OP_ADD:  cw = cw_assert(cw_assert(cw, CW_EU), CW_LA_BAR);
                        OP_SUB:  cw = cw_assert(cw_assert(cw_assert(cw, CW_EU), CW_LA_BAR), CW_SU);
                        default: cw = CW_INACTIVE;
                    endcase
                end
                default: cw = CW_INACTIVE;
            endcase
        end
    end

    assign cp      = cw[CW_CP];
    assign ep      = cw[CW_EP];
    assign lm_bar  = cw[CW_LM_BAR];
    assign ce_bar  = cw[CW_CE_BAR];
    assign li_bar  = cw[CW_LI_BAR];
    assign ei_bar  = cw[CW_EI_BAR];
    assign la_bar  = cw[CW_LA_BAR];
    assign ea      = cw[CW_EA];
    assign su      = cw[CW_SU];
    assign eu      = cw[CW_EU];
    assign lb_bar  = cw[CW_LB_BAR];
    assign lo_bar  = cw[CW_LO_BAR];
    assign lp_bar  = cw[CW_LP_BAR];
    assign t_state = ring_state;
    assign halted  = halted_q;

endmodule

// File: tb/tb_sap_controller.sv
// Self-checking bench for sap_controller: directed test-plan steps followed by
// randomized run/opcode/reset traffic, checked against a step-count model.
module tb_sap_controller;

    logic       clk = 1'b0;
    logic       rstn;
    logic       run;
    logic [3:0] opcode;
    logic       cp, ep, lm_bar, ce_bar, li_bar, ei_bar, la_bar;
    logic       ea, su, eu, lb_bar, lo_bar, lp_bar;
    logic [5:0] t_state;
    logic       halted;

    sap_controller dut (
        .clk     (clk),
        .rstn    (rstn),
        .run     (run),
        .opcode  (opcode),
        .cp      (cp),
        .ep      (ep),
        .lm_bar  (lm_bar),
        .ce_bar  (ce_bar),
        .li_bar  (li_bar),
        .ei_bar  (ei_bar),
        .la_bar  (la_bar),
        .ea      (ea),
        .su      (su),
        .eu      (eu),
        .lb_bar  (lb_bar),
        .lo_bar  (lo_bar),
        .lp_bar  (lp_bar),
        .t_state (t_state),
        .halted  (halted)
    );

    always #5 clk = ~clk;

    // Control signals in asserted sense (1 = doing its job), independent of polarity.
    typedef struct packed {
        logic cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, lp;
    } act_t;

    int m_step;   // 0 = idle, 1..6 = T1..T6
    bit m_halt;
    int n_total;
    int n_pass;
    int n_fail;

    function automatic act_t expect_ctrl(input int step, input logic [3:0] op,
                                         input logic r, input bit h);
        act_t a;
        a = '0;
        if (!r || h || step == 0) return a;
        case (step)
            1: begin a.ep = 1; a.lm = 1; end
            2: a.cp = 1;
            3: begin a.ce = 1; a.li = 1; end
            4: begin
                if (op == 4'h0 || op == 4'h1 || op == 4'h2) begin a.ei = 1; a.lm = 1; end
                else if (op == 4'hE) begin a.ea = 1; a.lo = 1; end
`ifdef SAP_CTRL_JMP_EN
                else if (op == 4'h3) begin a.ei = 1; a.lp = 1; end
`endif
            end
            5: begin
                if (op == 4'h0) begin a.ce = 1; a.la = 1; end
                else if (op == 4'h1 || op == 4'h2) begin a.ce = 1; a.lb = 1; end
            end
            6: begin
                if (op == 4'h1 || op == 4'h2) begin
                    a.eu = 1; a.la = 1; a.su = (op == 4'h2);
                end
            end
            default: ;
        endcase
        return a;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag);
        act_t obs;
        act_t expv;
        int   exp_t;
        obs   = {cp, ep, ~lm_bar, ~ce_bar, ~li_bar, ~ei_bar, ~la_bar,
                 ea, su, eu, ~lb_bar, ~lo_bar, ~lp_bar};
        expv  = expect_ctrl(m_step, opcode, run, m_halt);
        exp_t = (m_step == 0) ? 0 : (1 << (m_step - 1));
        $display("[%0t] %s run=%0b op=%h t_state=%b halted=%0b ctrl=%h",
                 $time, tag, run, opcode, t_state, halted, obs);
        chk({tag, "/t_state"}, 16'(t_state), 16'(exp_t));
        chk({tag, "/halted"}, 16'(halted), 16'(m_halt));
        chk({tag, "/ctrl"}, 16'(obs), 16'(expv));
    endtask

    // Drive inputs, check the settled outputs, then take one clock edge.
    task automatic cycle(input string tag, input logic r, input logic [3:0] op);
        run    = r;
        opcode = op;
        #2;
        check_all(tag);
        @(posedge clk);
        if (run && !m_halt) begin
            if (m_step == 4 && opcode == 4'hF) begin
                m_halt = 1;
                m_step = 0;
            end else begin
                m_step = (m_step == 6) ? 1 : m_step + 1;
            end
        end
        #1;
    endtask

    // Asynchronous reset pulse between edges; outputs are checked before any edge.
    task automatic rst_pulse(input string tag);
        rstn   = 1'b1;
        m_step = 0;
        m_halt = 0;
        #1;
        check_all(tag);
        rstn = 1'b0;
        #1;
    endtask

    initial begin
        logic       r;
        logic [3:0] op;
        n_total = 0;
        n_pass  = 0;
        n_fail  = 0;
        m_step  = 0;
        m_halt  = 0;
        rstn    = 1'b1;
        run     = 1'b0;
        opcode  = 4'h0;
        #2;
        check_all("reset");
        @(posedge clk);
        #1;
        rstn = 1'b0;

        repeat (13) cycle("lda", 1'b1, 4'h0);
        repeat (6)  cycle("add", 1'b1, 4'h1);
        repeat (6)  cycle("sub", 1'b1, 4'h2);
        repeat (6)  cycle("out", 1'b1, 4'hE);

        repeat (4)  cycle("hlt", 1'b1, 4'hF);
        for (int i = 0; i < 20; i++) cycle("halted", 1'b1, 4'($urandom_range(0, 15)));
        rst_pulse("unhalt");

        cycle("hold", 1'b1, 4'h0);
        cycle("hold", 1'b1, 4'h0);
        repeat (3) cycle("hold_off", 1'b0, 4'h0);
        repeat (5) cycle("hold_on", 1'b1, 4'h0);

        repeat (4) cycle("add_pre", 1'b1, 4'h1);
        run    = 1'b1;
        opcode = 4'h1;
        #1;
        check_all("add_t5");
        rst_pulse("rst_t5");
        repeat (7) cycle("restart", 1'b1, 4'h1);

        repeat (6) cycle("jmp", 1'b1, 4'h3);
        repeat (3) cycle("hlt_norun", 1'b1, 4'hF);
        repeat (2) cycle("hlt_norun", 1'b0, 4'hF);
        repeat (2) cycle("hlt_norun", 1'b1, 4'hF);
        rst_pulse("unhalt2");

        for (int i = 0; i < 400; i++) begin
            r  = ($urandom_range(0, 7) != 0);
            op = 4'($urandom_range(0, 15));
            if (op == 4'hF && $urandom_range(0, 3) != 0) op = 4'h0;
            if ($urandom_range(0, 59) == 0 || (m_halt && $urandom_range(0, 9) == 0))
                rst_pulse("rand_rst");
            cycle("rand", r, op);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sap_controller.md
# sap_controller

Control sequencer for the 8-bit SAP datapath. Provides a six-state T-state ring counter and decodes the instruction register's opcode nibble into the per-cycle control word. The control word drives the instruction register's load/output enables, and also the program counter, MAR, RAM, accumulator, ALU, B and output registers. The block sits beside the instruction register and owns all datapath sequencing, including halt.

## Interface
Parameters:
- none (all encodings are fixed constants in the package)

Ports:
- clk  input  1  system clock; all state changes on rising edge
- rstn  input  1  asynchronous, active-high reset (asserted = 1, despite the name)
- run  input  1  1 = sequencer advances each cycle; 0 = hold state, control word forced inactive
- opcode  input  4  instruction register output bits [7:4]; valid from T4 through T6
- cp  output  1  program counter increment (active-high)
- ep  output  1  program counter drives bus (active-high)
- lm_bar  output  1  MAR load (active-low)
- ce_bar  output  1  RAM drives bus (active-low)
- li_bar  output  1  instruction register load, i.e. its loadbar (active-low)
- ei_bar  output  1  instruction register output enable, i.e. its output_bar (active-low)
- la_bar  output  1  accumulator load (active-low)
- ea  output  1  accumulator drives bus (active-high)
- su  output  1  ALU subtract select (active-high)
- eu  output  1  ALU drives bus (active-high)
- lb_bar  output  1  B register load (active-low)
- lo_bar  output  1  output register load (active-low)
- lp_bar  output  1  program counter load from bus (active-low)
- t_state  output  6  one-hot ring value; bit0 = T1 … bit5 = T6; 0 = IDLE
- halted  output  1  sticky halt flag

## Operation
- Inactive control word: every *_bar = 1, every active-high signal = 0.
- State register: one-hot ring with the sequence IDLE → T1 → T2 → T3 → T4 → T5 → T6 → T1. IDLE is entered only by reset or halt.
- Advance occurs on clk only when run = 1 and halted = 0. Otherwise the ring holds.
- The control word is a combinational decode of t_state and opcode, gated inactive when run = 0, halted = 1, or t_state = IDLE.
- Fetch (all opcodes):
  - T1: ep = 1, lm_bar = 0
  - T2: cp = 1
  - T3: ce_bar = 0, li_bar = 0
- Execute:
  - LDA 4'h0: T4 ei_bar = 0, lm_bar = 0; T5 ce_bar = 0, la_bar = 0; T6 none.
  - ADD 4'h1: T4 as LDA; T5 ce_bar = 0, lb_bar = 0; T6 eu = 1, la_bar = 0.
  - SUB 4'h2: as ADD, with su = 1 during T6.
  - JMP 4'h3: see Configuration.
  - OUT 4'hE: T4 ea = 1, lo_bar = 0; T5 and T6 none.
  - HLT 4'hF: T4 outputs inactive. On the edge ending T4, halted ← 1 and the ring ← IDLE.
  - Any other opcode: NOP, so T4–T6 are inactive.
- halted stays 1 until reset. run has no effect while halted.

## Timing
- Reset values: t_state = 6'b000000, halted = 0, all controls inactive.
- First rising edge with rstn = 0 and run = 1 moves IDLE → T1. T1 controls appear that cycle.
- Instruction period: 6 clk cycles. Fetch occupies 3 cycles.
- Reset asserted mid-instruction takes effect immediately and asynchronously: the ring goes to IDLE, halted goes to 0, and outputs go inactive within the same cycle.
- run deasserted mid-instruction: the state freezes and controls go inactive. When run returns to 1, the same T-state's controls reappear, and the state advances at the next edge. No state is skipped or repeated twice.
- HLT with run = 0 during T4: halt is not taken until run = 1 at an edge in T4.

## Configuration
- Macro SAP_CTRL_JMP_EN.
- When defined: opcode 4'h3 = JMP, with T4 ei_bar = 0 and lp_bar = 0, and T5–T6 none.
- When undefined: 4'h3 is a NOP. lp_bar is permanently 1, and the port remains present.

## Structure
- Package sap_ctrl_pkg holds:
  - opcode constants OP_LDA, OP_ADD, OP_SUB, OP_JMP, OP_OUT, OP_HLT
  - one-hot T-state constants T_IDLE, T1–T6
  - control-word bit index constants and the inactive control-word constant
- Sub-module sap_ring_counter owns the ring. Its inputs are clk, rstn, advance, and clear_to_idle; its output is t_state. The top level holds the halt flag and the decode.

## Test plan
- Reset and run = 1, opcode = 4'h0: t_state steps 000000 → 000001 → 000010 → … → 100000 → 000001. Controls match LDA: T4 ei_bar = lm_bar = 0; T5 ce_bar = la_bar = 0.
- opcode = 4'h2: at T6, su = 1, eu = 1, la_bar = 0. With opcode = 4'h1, T6 has su = 0.
- opcode = 4'hF: T4 outputs inactive. Next edge gives halted = 1 and t_state = 0. Then 20 cycles with run = 1 leave everything unchanged. Reset clears halted.
- run = 0 for 3 cycles during T2: cp = 0 and t_state = 000010 throughout. After run = 1, cp = 1 for exactly one cycle.
- rstn pulse during T5 of ADD: t_state = 0 and lb_bar = 1 without waiting for a clk edge. Restart begins at T1.
- opcode = 4'h3: with SAP_CTRL_JMP_EN, T4 has lp_bar = 0 and ei_bar = 0. Without it, T4–T6 are fully inactive.
